// File: rtl/token_thin_sched_pkg.sv
// Shared constants, types and helpers for the token thinning scheduler.
// The TOKEN_THIN_SCHED_STRICT_PRIO_EN macro is consumed by the top level.
package token_thin_sched_pkg;

  localparam int N_PORTS_DEF = 4;
  localparam int CNT_W_DEF   = 4;
  localparam int SHIFT_W_DEF = 2;

  typedef logic [SHIFT_W_DEF-1:0] shift_t;

  // Terminal phase value: the token arriving at this phase is the one kept.
  function automatic int unsigned max_phase(input int unsigned shift);
    return (32'd1 << shift) - 32'd1;
  endfunction

endpackage

// File: rtl/token_thin_sched_cell.sv
// Per-port thinning state: shift, phase counter, pending counter and sticky overflow.
// One instance per requester port. Pending count saturates instead of wrapping.
module token_thin_cell
  import token_thin_sched_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               a_i,
  input  logic               grant_i,
  input  logic               cfg_we_i,
  input  logic [SHIFT_W-1:0] cfg_shift_i,
  input  logic               ovf_clr_i,
  output logic               nz_o,
  output logic               ovf_o
);

  localparam int PH_W = (1 << SHIFT_W) - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               keep, accept, ovf_set;

  always_comb begin
    keep    = a_i && (phase_q == PH_W'(max_phase(int'(shift_q))));
    // A grant on this port frees a slot in the same cycle, so a full counter still accepts.
    accept  = keep && ((count_q != CNT_MAX) || grant_i);
    ovf_set = keep && !accept;

    shift_d = shift_q;
    phase_d = phase_q;
    if (a_i) phase_d = keep ? '0 : phase_q + PH_W'(1);
    if (cfg_we_i) begin
      shift_d = cfg_shift_i;
      phase_d = '0;
    end

    count_d = count_q;
    if (accept && !grant_i)      count_d = count_q + CNT_W'(1);
    else if (grant_i && !accept) count_d = count_q - CNT_W'(1);

    ovf_d = ovf_q;
    if (ovf_clr_i) ovf_d = 1'b0;
    if (ovf_set)   ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= SHIFT_W'(1);
      phase_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      phase_q <= phase_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign nz_o  = (count_q != '0);
  assign ovf_o = ovf_q;

endmodule

// File: rtl/token_thin_sched.sv
// Shares one serial token output among N_PORTS thinned token inputs (round-robin drain).
// Define TOKEN_THIN_SCHED_STRICT_PRIO_EN for fixed lowest-index-first priority instead.
module token_thin_sched
  import token_thin_sched_pkg::*;
#(
  parameter int N_PORTS = N_PORTS_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_PORTS-1:0]         a,
  input  logic                       cfg_we,
  input  logic [$clog2(N_PORTS)-1:0] cfg_port,
  input  logic [SHIFT_W-1:0]         cfg_shift,
  input  logic                       ovf_clr,
  input  logic                       out_ready,
  output logic                       b,
  output logic [$clog2(N_PORTS)-1:0] b_id,
  output logic [N_PORTS-1:0]         pending_nz,
  output logic [N_PORTS-1:0]         ovf
);

  localparam int IDX_W = $clog2(N_PORTS);

  logic [N_PORTS-1:0] nz, grant, cfg_sel;
  logic               gnt_valid;
  logic [IDX_W-1:0]   gnt_idx;
  logic               b_q;
  logic [IDX_W-1:0]   b_id_q;

  for (genvar i = 0; i < N_PORTS; i++) begin : g_cell
    assign cfg_sel[i] = cfg_we && (cfg_port == IDX_W'(i));

    token_thin_cell #(.CNT_W(CNT_W), .SHIFT_W(SHIFT_W)) u_cell (
      .clk_i      (clk),
      .rst_ni     (rst),
      .a_i        (a[i]),
      .grant_i    (grant[i]),
      .cfg_we_i   (cfg_sel[i]),
      .cfg_shift_i(cfg_shift),
      .ovf_clr_i  (ovf_clr),
      .nz_o       (nz[i]),
      .ovf_o      (ovf[i])
    );
  end

`ifdef TOKEN_THIN_SCHED_STRICT_PRIO_EN
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    // Descending scan: the last hit, i.e. the lowest index, wins.
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (nz[i]) begin
        gnt_valid = out_ready;
        gnt_idx   = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] rr_q, rr_d;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    // Scan from farthest to nearest so the first port after rr_q is the final winner.
    for (int k = N_PORTS; k >= 1; k--) begin
      if (nz[(int'(rr_q) + k) % N_PORTS]) begin
        gnt_valid = out_ready;
        gnt_idx   = IDX_W'((int'(rr_q) + k) % N_PORTS);
      end
    end
    rr_d = gnt_valid ? gnt_idx : rr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_q <= IDX_W'(N_PORTS - 1);
    else      rr_q <= rr_d;
  end
`endif

  always_comb begin
    grant = '0;
    if (gnt_valid) grant[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_q    <= 1'b0;
      b_id_q <= '0;
    end else begin
      b_q    <= gnt_valid;
      b_id_q <= gnt_idx;
    end
  end

  assign b          = b_q;
  assign b_id       = b_id_q;
  assign pending_nz = nz;

endmodule
